// File: rtl/sm_pkg.sv
// Shared types and constants for the sign-magnitude result stage.
package sm_pkg;

    // Word width of the upstream sign-magnitude subtractor.
    localparam int SM_N = 8;

    // Sign-magnitude word: MSB is the sign, the rest is the magnitude.
    typedef struct packed {
        logic              sign;
        logic [SM_N-2:0]   mag;
    } sm_word_t;

    // All-ones magnitude, used as the saturated value.
    localparam logic [SM_N-2:0] SM_MAG_MAX = '1;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The output register holds the
// head word; the skid register catches one extra word while the consumer
// stalls. Both handshake outputs are decoded from the state register only.
module sm_skid_buf
    import sm_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    skid_state_t  state_reg;
    skid_state_t  state_next;
    logic [W-1:0] out_reg;
    logic [W-1:0] skid_reg;
    logic         accept;
    logic         deliver;

    assign accept  = up_valid && up_ready;
    assign deliver = dn_valid && dn_ready;
    assign dn_data = out_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic from accept/deliver events.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) state_next = ONE;
            end
            ONE: begin
                if (accept && !deliver)      state_next = TWO;
                else if (!accept && deliver) state_next = EMPTY;
            end
            TWO: begin
                if (deliver) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Handshake outputs depend on the state register alone.
    always_comb begin
        up_ready = (state_reg != TWO);
        dn_valid = (state_reg != EMPTY);
    end

    // Data path: load head or skid entry, shift skid to head on drain.
    always_ff @(posedge clk) begin
        if (srst) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) out_reg <= up_data;
                end
                ONE: begin
                    if (accept && deliver) out_reg  <= up_data;
                    else if (accept)       skid_reg <= up_data;
                end
                TWO: begin
                    if (deliver) out_reg <= skid_reg;
                end
                default: begin
                    out_reg <= out_reg;
                end
            endcase
        end
    end

endmodule

// File: rtl/sm_result_stage.sv
// Registered output stage after the sign-magnitude subtractor: normalises
// negative zero, flags (and optionally saturates) carry results, buffers
// them through a 2-entry skid buffer and counts overflow events.
// Build option: define SM_SAT_EN to force the magnitude to all ones on carry;
// otherwise the wrapped magnitude is passed through and only o_ovf is set.
module sm_result_stage
    import sm_pkg::*;
#(
    parameter int N = SM_N,
    parameter int C = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_data,
    input  logic         i_carry,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [N-1:0] o_data,
    output logic         o_ovf,
    output logic         o_valid,
    input  logic         i_ready,
    input  logic         i_clr,
    output logic [C-1:0] o_ovf_cnt
);

    localparam logic [C-1:0] CNT_MAX = '1;
    localparam logic [C-1:0] CNT_ONE = C'(1);

    logic         in_sign;
    logic [N-2:0] in_mag;
    logic [N-2:0] carry_mag;
    logic [N-1:0] norm_data;
    logic         norm_ovf;
    logic         accept;
    logic         count_evt;
    logic [C-1:0] cnt_reg;
    logic [C-1:0] cnt_next;

    assign in_sign = i_data[N-1];
    assign in_mag  = i_data[N-2:0];

`ifdef SM_SAT_EN
    // Saturation: every magnitude bit is forced high when carry is set.
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_sat
        assign carry_mag[gi] = in_mag[gi] | i_carry;
    end
`else
    // Wrap: the magnitude goes through untouched; o_ovf carries the news.
    assign carry_mag = in_mag;
`endif

    // Normalisation of the incoming word before it is stored.
    always_comb begin
        norm_data = i_data;
        norm_ovf  = 1'b0;
        if (i_carry) begin
            norm_data = {in_sign, carry_mag};
            norm_ovf  = 1'b1;
        end else if (in_sign && (in_mag == '0)) begin
            norm_data = '0;
        end
    end

    sm_skid_buf #(
        .W (N + 1)
    ) u_skid (
        .clk      (i_clk),
        .srst     (i_rst),
        .up_data  ({norm_ovf, norm_data}),
        .up_valid (i_valid),
        .up_ready (o_ready),
        .dn_data  ({o_ovf, o_data}),
        .dn_valid (o_valid),
        .dn_ready (i_ready)
    );

    assign accept    = i_valid && o_ready;
    assign count_evt = accept && i_carry;

    // Counter update: clear first, then count the event of this same edge.
    always_comb begin
        cnt_next = cnt_reg;
        if (i_clr) begin
            cnt_next = count_evt ? CNT_ONE : '0;
        end else if (count_evt && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // Overflow event counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign o_ovf_cnt = cnt_reg;

endmodule

// File: tb/tb_sm_result_stage.sv
// Directed bench for sm_result_stage (N=8, C=2) with a queue-based model
// checked every cycle plus literal expectations for the key scenarios.
module tb_sm_result_stage;

    localparam int N = 8;
    localparam int C = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] din;
    logic         carry;
    logic         vin;
    logic         rdy_out;
    logic [N-1:0] dout;
    logic         ovf;
    logic         vout;
    logic         rdy_in;
    logic         clr;
    logic [C-1:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sm_result_stage #(.N(N), .C(C)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (din),
        .i_carry   (carry),
        .i_valid   (vin),
        .o_ready   (rdy_out),
        .o_data    (dout),
        .o_ovf     (ovf),
        .o_valid   (vout),
        .i_ready   (rdy_in),
        .i_clr     (clr),
        .o_ovf_cnt (cnt)
    );

    // ---------------- model ----------------
    logic [N:0] mq[$];          // {ovf, data}
    int         m_cnt = 0;
    bit         m_live = 0;

    function automatic logic [N:0] expect_word(logic [N-1:0] d, logic c);
        logic [N:0] w;
        if (c) begin
`ifdef SM_SAT_EN
            w = {1'b1, d[N-1], {(N-1){1'b1}}};
`else
            w = {1'b1, d};
`endif
        end else if (d == 8'h80) begin
            w = '0;
        end else begin
            w = {1'b0, d};
        end
        return w;
    endfunction

    always @(posedge clk) begin
        bit acc, del, cevt;
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_live = 1;
        end else if (m_live) begin
            acc  = vin && (mq.size() < 2);
            del  = rdy_in && (mq.size() > 0);
            cevt = acc && carry;
            if (del) void'(mq.pop_front());
            if (acc) mq.push_back(expect_word(din, carry));
            if (clr)                          m_cnt = cevt ? 1 : 0;
            else if (cevt && m_cnt < (1 << C) - 1) m_cnt = m_cnt + 1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("model_valid", 32'(vout), 32'(mq.size() > 0));
            chk("model_ready", 32'(rdy_out), 32'(mq.size() < 2));
            chk("model_cnt", 32'(cnt), 32'(m_cnt));
            if (mq.size() > 0) chk("model_word", 32'({ovf, dout}), 32'(mq[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(logic v, logic [7:0] d, logic c, logic r, logic cl);
        vin = v; din = d; carry = c; rdy_in = r; clr = cl;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sat83;
    logic [C-1:0] cnt_seq [5];

    initial begin
`ifdef SM_SAT_EN
        sat83 = 8'hFF;
`else
        sat83 = 8'h83;
`endif
        cnt_seq[0] = 2'd1; cnt_seq[1] = 2'd2; cnt_seq[2] = 2'd3;
        cnt_seq[3] = 2'd3; cnt_seq[4] = 2'd3;

        rst = 1'b1;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        rst = 1'b0;
        chk("rst_valid", 32'(vout), 0);
        chk("rst_ready", 32'(rdy_out), 1);
        chk("rst_data", 32'(dout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cnt", 32'(cnt), 0);

        // Plain word, negative zero, carry word.
        step(1, 8'h85, 0, 1, 0);
        chk("w85_data", 32'(dout), 32'h85);
        chk("w85_ovf", 32'(ovf), 0);
        chk("w85_valid", 32'(vout), 1);
        step(1, 8'h80, 0, 1, 0);
        chk("negzero", 32'(dout), 0);
        step(1, 8'h83, 1, 1, 0);
        chk("carry_data", 32'(dout), 32'(sat83));
        chk("carry_ovf", 32'(ovf), 1);
        chk("carry_cnt", 32'(cnt), 1);
        step(0, 8'h00, 0, 1, 0);
        chk("drain_valid", 32'(vout), 0);

        // Backpressure: fill both entries, third word must wait.
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        chk("full_ready", 32'(rdy_out), 0);
        chk("full_head", 32'(dout), 32'h01);
        step(1, 8'h03, 0, 0, 0);
        chk("held_ready", 32'(rdy_out), 0);
        chk("held_head", 32'(dout), 32'h01);
        step(1, 8'h03, 0, 1, 0);
        chk("order_2", 32'(dout), 32'h02);
        step(1, 8'h03, 0, 1, 0);
        chk("order_3", 32'(dout), 32'h03);
        step(0, 8'h00, 0, 1, 0);
        chk("bp_empty", 32'(vout), 0);

        // Streaming: accept and deliver together every cycle.
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h10 + 8'(i), 0, 1, 0);
            chk("stream_valid", 32'(vout), 1);
            chk("stream_data", 32'(dout), 32'(8'h10 + 8'(i)));
        end
        step(0, 8'h00, 0, 1, 0);

        // Counter saturation and clear.
        step(0, 8'h00, 0, 1, 1);
        chk("clr_cnt", 32'(cnt), 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h05 + 8'(i), 1, 1, 0);
            chk("sat_cnt", 32'(cnt), 32'(cnt_seq[i]));
        end
        step(1, 8'h80, 1, 1, 1);
        chk("clr_evt_cnt", 32'(cnt), 1);
        step(0, 8'h00, 0, 1, 1);
        chk("clr_only_cnt", 32'(cnt), 0);
        step(1, 8'h7F, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);

        // Reset while full with a word offered.
        step(1, 8'h11, 1, 0, 0);
        step(1, 8'h12, 0, 0, 0);
        chk("pre_rst_ready", 32'(rdy_out), 0);
        rst = 1'b1;
        step(1, 8'h13, 1, 1, 0);
        rst = 1'b0;
        chk("mrst_valid", 32'(vout), 0);
        chk("mrst_ready", 32'(rdy_out), 1);
        chk("mrst_data", 32'(dout), 0);
        chk("mrst_cnt", 32'(cnt), 0);
        step(0, 8'h00, 0, 1, 0);
        chk("mrst_nostore", 32'(vout), 0);
        step(0, 8'h00, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm_result_stage.md
# sm_result_stage

Registered output stage directly downstream of the sign-magnitude subtractor. Each cycle it takes the subtractor's combinational result word and carry. It normalises negative zero, optionally saturates on carry, and tags the word with an overflow flag. It then delivers the word through a 2-entry valid/ready skid buffer and keeps a saturating overflow-event counter. This breaks the combinational path from the subtractor to the consumer and absorbs consumer backpressure without dropping results.

## Interface
- N, 8, word width in sign-magnitude; MSB is sign, [N-2:0] is magnitude; must match the subtractor's N.
- C, 8, overflow counter width.
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  N  subtractor result (sign-magnitude).
- i_carry  in  1  subtractor carry/borrow out (magnitude overflow).
- i_valid  in  1  producer has a word on i_data/i_carry.
- o_ready  out  1  stage can accept a word this cycle.
- o_data  out  N  normalised result word.
- o_ovf  out  1  carry flag travelling with o_data.
- o_valid  out  1  o_data/o_ovf hold a word.
- i_ready  in  1  consumer takes the word this cycle.
- i_clr  in  1  synchronous clear of o_ovf_cnt.
- o_ovf_cnt  out  C  number of accepted words with i_carry=1, saturating.

## Operation
- Accept: i_valid && o_ready at a rising edge. Deliver: o_valid && i_ready at a rising edge.
- Normalisation is applied on accept and affects only the stored word:
  - Negative zero (sign=1, magnitude=0, carry=0) is stored as all-zero.
  - Carry=1: the stored ovf flag is 1; magnitude handling depends on SM_SAT_EN.
  - Otherwise the word is stored unchanged, with ovf=0.
- Skid buffer FSM, states EMPTY, ONE, TWO:
  - EMPTY: accept -> ONE.
  - ONE: accept without deliver -> TWO. Deliver without accept -> EMPTY. Both -> ONE, holding the new word.
  - TWO: deliver -> ONE, with the skid entry moved to the output. Accept is impossible because o_ready=0.
- o_valid = (state != EMPTY). o_ready = (state != TWO). Both are decoded from the state register only; there is no combinational path from i_valid or i_ready to any output.
- Order is strictly FIFO. While o_valid=1 and no deliver occurs, o_data/o_ovf remain stable.
- Counter behaviour:
  - Increments by 1 on every accept with i_carry=1, holding at 2^C-1.
  - i_clr with no counting accept -> 0.
  - i_clr together with a counting accept -> 1, because the new event is counted after the clear.

## Timing
- Latency: a word accepted at edge k appears on o_data with o_valid=1 after edge k, so it is visible in cycle k+1.
- Throughput: 1 word/cycle while i_ready=1.
- After 2 accepts with i_ready=0, o_ready=0 from the following cycle.
- o_ovf_cnt updates at the accepting edge.
- Reset values: state EMPTY, o_valid=0, o_ready=1, o_data=0, o_ovf=0, o_ovf_cnt=0.
- i_rst asserted mid-operation discards both stored entries at that edge. Any accept or deliver in the same cycle is ignored, and i_rst overrides i_clr.

## Configuration
- SM_SAT_EN defined: on carry=1 the stored magnitude is forced to all ones (2^(N-1)-1) and the sign is kept. For N=8 this gives 0x7F or 0xFF.
- SM_SAT_EN undefined: on carry=1 the magnitude is stored wrapped, i.e. i_data unchanged, and o_ovf=1 is the only indication.
- Handshake, counter and negative-zero rules are identical in both builds.

## Structure
- Package sm_pkg holds:
  - typedef sm_word_t, a packed struct {logic sign; logic [N-2:0] mag} with N from the package constant SM_N=8;
  - constant SM_MAG_MAX, all-ones magnitude;
  - enum skid_state_t {EMPTY, ONE, TWO}.
- Sub-module sm_skid_buf is the generic 2-entry valid/ready buffer of width N+1, data plus ovf, containing the FSM.
- The top level holds normalisation, saturation and the counter.

## Test plan
- N=8: push 0x85 with carry 0, i_ready=1 -> o_data=0x85, o_ovf=0 one cycle later. Push 0x80 with carry 0 -> o_data=0x00.
- Push 0x83 with carry 1 -> SM_SAT_EN build: o_data=0xFF, o_ovf=1. Non-SAT build: o_data=0x83, o_ovf=1. Both builds: o_ovf_cnt=1.
- Hold i_ready=0 and offer 0x01, 0x02, 0x03 on consecutive cycles -> 0x01 and 0x02 accepted, o_ready=0 on the third cycle, 0x03 held. Release i_ready -> output order 0x01, 0x02, 0x03 with no loss.
- Simultaneous accept and deliver in state ONE over 10 cycles -> o_valid stays 1 and one word is delivered per cycle.
- C=2: 5 carry words -> o_ovf_cnt = 1, 2, 3, 3, 3. i_clr with a carry word in the same cycle -> 1.
- Assert i_rst in state TWO with i_valid=1 -> next cycle o_valid=0, o_ready=1, o_data=0, o_ovf_cnt=0, and the offered word is not stored.
